btb_gshare_predictor: RTL and testbench

// Fetch-stage branch predictor: decodes the fetched MIPS instruction, looks up a direct-mapped

---
 rtl/btb_gshare_predictor.sv | 149 ++++++++++++++
 tb/tb_btb_gshare_predictor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/btb_gshare_predictor.sv
// btb_gshare_predictor
// Fetch-stage branch predictor. Decodes the fetched MIPS instruction, looks it
// up in a direct-mapped branch target buffer and a gshare pattern history
// table, and registers a taken/target prediction one cycle later. The tables
// are trained from the branch or jump currently resolving in MEM.
//
// Ports
//   CLK                   rising-edge clock
//   RESET                 asynchronous, active-low reset
//   FLUSH                 synchronous clear of Taken/Taken_addr (tables still train)
//   Instr_input           instruction being fetched
//   Instr_addr_input      PC of Instr_input
//   Branch_instr          instruction in MEM (training source)
//   Branch_addr           PC of Branch_instr
//   Branch_resolved       1 = Branch_instr was actually taken
//   Branch_resolved_addr  actual target of Branch_instr
//   Taken                 registered prediction: redirect fetch
//   Taken_addr            registered BTB target (0 on BTB miss)
module btb_gshare_predictor #(
  parameter int BTB_IDX_BITS = 6,
  parameter int GHR_BITS     = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic [31:0] Instr_input,
  input  logic [31:0] Instr_addr_input,
  input  logic [31:0] Branch_instr,
  input  logic [31:0] Branch_addr,
  input  logic        Branch_resolved,
  input  logic [31:0] Branch_resolved_addr,
  output logic        Taken,
  output logic [31:0] Taken_addr
);

  localparam int BTB_SIZE = 1 << BTB_IDX_BITS;
  localparam int PHT_SIZE = 1 << GHR_BITS;
  localparam int TAG_LSB  = BTB_IDX_BITS + 2;
  localparam int TAG_BITS = 32 - TAG_LSB;

  function automatic logic is_cond(input logic [5:0] op, input logic [4:0] rt);
    logic r;
    r = 1'b0;
    case (op)
      6'h04, 6'h05, 6'h06, 6'h07,
      6'h14, 6'h15, 6'h16, 6'h17: r = 1'b1;
      6'h01: r = (rt == 5'h00) || (rt == 5'h01) || (rt == 5'h02) ||
                 (rt == 5'h03) || (rt == 5'h10) || (rt == 5'h11);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_jump(input logic [5:0] op, input logic [5:0] funct);
    return (op == 6'h02) || (op == 6'h03) ||
           ((op == 6'h00) && ((funct == 6'h08) || (funct == 6'h09)));
  endfunction

  logic [BTB_SIZE-1:0] btb_valid;
  logic [TAG_BITS-1:0] btb_tag [BTB_SIZE];
  logic [31:0]         btb_tgt [BTB_SIZE];
  logic [1:0]          pht     [PHT_SIZE];
  logic [GHR_BITS-1:0] ghr;

  // Fetch-side lookup: reads pre-edge table contents, so an entry being
  // trained this cycle is seen with its old value.
  logic [BTB_IDX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0]     f_tag;
  logic [GHR_BITS-1:0]     f_pht_idx;
  logic                    f_hit;
  logic                    f_dir;
  logic                    f_cond;
  logic                    f_jump;
  logic                    f_pred;

  assign f_idx     = Instr_addr_input[BTB_IDX_BITS+1:2];
  assign f_tag     = Instr_addr_input[31:TAG_LSB];
  assign f_pht_idx = ghr ^ Instr_addr_input[GHR_BITS+1:2];
  assign f_hit     = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign f_dir     = pht[f_pht_idx][1];
  assign f_cond    = is_cond(Instr_input[31:26], Instr_input[20:16]);
  assign f_jump    = is_jump(Instr_input[31:26], Instr_input[5:0]);
  assign f_pred    = f_jump ? f_hit : (f_cond ? (f_dir & f_hit) : 1'b0);

  // Resolve-side training signals.
  logic [BTB_IDX_BITS-1:0] b_idx;
  logic [GHR_BITS-1:0]     b_pht_idx;
  logic                    b_cond;
  logic                    b_jump;
  logic [1:0]              b_ctr;
  logic [1:0]              b_ctr_next;

  assign b_idx     = Branch_addr[BTB_IDX_BITS+1:2];
  assign b_pht_idx = ghr ^ Branch_addr[GHR_BITS+1:2];
  assign b_cond    = is_cond(Branch_instr[31:26], Branch_instr[20:16]);
  assign b_jump    = is_jump(Branch_instr[31:26], Branch_instr[5:0]);
  assign b_ctr     = pht[b_pht_idx];

  always_comb begin
    b_ctr_next = b_ctr;
    if (Branch_resolved) begin
      if (b_ctr != 2'b11) b_ctr_next = b_ctr + 2'b01;
    end else begin
      if (b_ctr != 2'b00) b_ctr_next = b_ctr - 2'b01;
    end
  end

  // Instruction fields the decoder never looks at, and word-offset PC bits.
  logic unused_bits;
  assign unused_bits = ^{Instr_input[25:21], Instr_input[15:6],
                         Branch_instr[25:21], Branch_instr[15:6],
                         Instr_addr_input[1:0], Branch_addr[1:0]};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Taken      <= 1'b0;
      Taken_addr <= 32'h0;
    end else if (FLUSH) begin
      Taken      <= 1'b0;
      Taken_addr <= 32'h0;
    end else begin
      Taken      <= f_pred;
      Taken_addr <= f_hit ? btb_tgt[f_idx] : 32'h0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ghr       <= '0;
      btb_valid <= '0;
      for (int i = 0; i < PHT_SIZE; i++) pht[i] <= 2'b01;
    end else begin
      if ((b_cond || b_jump) && Branch_resolved) btb_valid[b_idx] <= 1'b1;
      if (b_cond) begin
        pht[b_pht_idx] <= b_ctr_next;
        ghr            <= {ghr[GHR_BITS-2:0], Branch_resolved};
      end
    end
  end

  // Tag and target storage carries no reset; a stale entry is masked by valid.
  always_ff @(posedge CLK) begin
    if ((b_cond || b_jump) && Branch_resolved) begin
      btb_tag[b_idx] <= Branch_addr[31:TAG_LSB];
      btb_tgt[b_idx] <= Branch_resolved_addr;
    end
  end

endmodule

// File: tb/tb_btb_gshare_predictor.sv
module tb_btb_gshare_predictor;

  logic        CLK;
  logic        RESET;
  logic        FLUSH;
  logic [31:0] Instr_input;
  logic [31:0] Instr_addr_input;
  logic [31:0] Branch_instr;
  logic [31:0] Branch_addr;
  logic        Branch_resolved;
  logic [31:0] Branch_resolved_addr;
  logic        Taken;
  logic [31:0] Taken_addr;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] BEQ  = 32'h10000003;
  localparam logic [31:0] J    = 32'h08100000;
  localparam logic [31:0] JAL  = 32'h0C100000;
  localparam logic [31:0] JR   = 32'h03E00008;
  localparam logic [31:0] ADD  = 32'h01095020;
  localparam logic [31:0] BGEZ = 32'h04010004;
  localparam logic [31:0] NOP  = 32'h00000000;

  btb_gshare_predictor dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .FLUSH                (FLUSH),
    .Instr_input          (Instr_input),
    .Instr_addr_input     (Instr_addr_input),
    .Branch_instr         (Branch_instr),
    .Branch_addr          (Branch_addr),
    .Branch_resolved      (Branch_resolved),
    .Branch_resolved_addr (Branch_resolved_addr),
    .Taken                (Taken),
    .Taken_addr           (Taken_addr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] addr);
    Instr_input      = instr;
    Instr_addr_input = addr;
    cyc();
  endtask

  task automatic resolve(input logic [31:0] instr, input logic [31:0] addr,
                         input logic taken, input logic [31:0] tgt);
    Branch_instr         = instr;
    Branch_addr          = addr;
    Branch_resolved      = taken;
    Branch_resolved_addr = tgt;
    cyc();
    Branch_instr    = NOP;
    Branch_resolved = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic t, input logic [31:0] a);
    chk({tag, ".taken"}, {31'h0, Taken}, {31'h0, t});
    chk({tag, ".addr"}, Taken_addr, a);
  endtask

  initial begin
    RESET = 1'b0;
    FLUSH = 1'b0;
    Instr_input = NOP;
    Instr_addr_input = 32'h0;
    Branch_instr = NOP;
    Branch_addr = 32'h0;
    Branch_resolved = 1'b0;
    Branch_resolved_addr = 32'h0;
    repeat (2) @(negedge CLK);
    expect_out("reset", 1'b0, 32'h0);
    RESET = 1'b1;

    fetch(BEQ, 32'h00400010);
    expect_out("cold_beq", 1'b0, 32'h0);

    // First taken resolve: ctr[0x04] -> 2, GHR=0x01. Fetch indexes 0x05 (still weak NT).
    resolve(BEQ, 32'h00400010, 1'b1, 32'h00400000);
    fetch(BEQ, 32'h00400010);
    expect_out("beq_weak", 1'b0, 32'h00400000);

    // J resolved under FLUSH: outputs cleared, BTB still trained.
    Instr_input = NOP;
    Instr_addr_input = 32'h00400010;
    FLUSH = 1'b1;
    resolve(J, 32'h00400020, 1'b1, 32'h00400000);
    FLUSH = 1'b0;
    expect_out("flush_train", 1'b0, 32'h0);
    fetch(J, 32'h00400020);
    expect_out("j_hit", 1'b1, 32'h00400000);

    // JAL fills BTB at 0x014 without touching GHR; a BEQ fetched there then
    // indexes GHR(0x01)^0x05 = 0x04, whose counter is 2 -> taken.
    resolve(JAL, 32'h00400014, 1'b1, 32'h00400100);
    fetch(BEQ, 32'h00400014);
    expect_out("ghr_kept", 1'b1, 32'h00400100);

    // Nine more taken resolves: GHR 01..FF, ctr[0xFB] reaches 3.
    for (int i = 0; i < 9; i++) resolve(BEQ, 32'h00400010, 1'b1, 32'h00400000);
    fetch(BEQ, 32'h00400010);
    expect_out("beq_trained", 1'b1, 32'h00400000);

    fetch(BEQ, 32'h00400110);
    expect_out("tag_miss", 1'b0, 32'h0);

    resolve(JR, 32'h00400040, 1'b1, 32'h00400200);
    fetch(JR, 32'h00400040);
    expect_out("jr_hit", 1'b1, 32'h00400200);

    resolve(ADD, 32'h00400030, 1'b1, 32'h00400300);
    fetch(J, 32'h00400030);
    expect_out("nonbr_no_train", 1'b0, 32'h0);

    // Saturation at 3, then one not-taken (3->2, BTB untouched), then eight
    // taken resolves walk GHR back to 0xFF without hitting index 0xFB.
    resolve(BEQ, 32'h00400010, 1'b1, 32'h00400000);
    resolve(BEQ, 32'h00400010, 1'b0, 32'hDEADBEEC);
    for (int i = 0; i < 8; i++) resolve(BEQ, 32'h00400010, 1'b1, 32'h00400000);
    fetch(BEQ, 32'h00400010);
    expect_out("saturate", 1'b1, 32'h00400000);

    fetch(ADD, 32'h00400010);
    expect_out("add_hit", 1'b0, 32'h00400000);

    Instr_input = BEQ;
    Instr_addr_input = 32'h00400010;
    FLUSH = 1'b1;
    cyc();
    expect_out("flush", 1'b0, 32'h0);
    FLUSH = 1'b0;
    cyc();
    expect_out("unflush", 1'b1, 32'h00400000);

    RESET = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    fetch(BEQ, 32'h00400010);
    expect_out("post_reset", 1'b0, 32'h0);

    // REGIMM BGEZ trains the BTB; GHR=1 after it so fetch indexes weak-NT 0x15.
    resolve(BGEZ, 32'h00400050, 1'b1, 32'h00400300);
    fetch(BGEZ, 32'h00400050);
    expect_out("regimm", 1'b0, 32'h00400300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
